// File: rtl/router_pkg.sv
// router_pkg: shared arbiter state encoding, packet header field positions and defaults
// for the router output arbiter.
package router_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HDR   = 2'd2,
        BODY  = 2'd3
    } state_t;

    localparam int ADDR_W  = 2;
    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = ADDR_W;
    localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;
    // Payload length plus the parity byte needs one extra bit (63 + 1 = 64).
    localparam int REM_W   = LEN_W + 1;

    localparam int TIMEOUT_DEFAULT = 30;

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/router_rr_pick.sv
// router_rr_pick: combinational round-robin chooser over three requesters,
// searching upward from the requester after 'last'.
module router_rr_pick
    import router_pkg::*;
(
    input  logic [2:0] request,
    input  logic [1:0] last,
    output logic [1:0] index,
    output logic       any
);

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        index = 2'd0;
        any   = |request;
        case (last)
            2'd0: begin
                if (request[1])      index = 2'd1;
                else if (request[2]) index = 2'd2;
                else                 index = 2'd0;
            end
            2'd1: begin
                if (request[2])      index = 2'd2;
                else if (request[0]) index = 2'd0;
                else                 index = 2'd1;
            end
            default: begin
                if (request[0])      index = 2'd0;
                else if (request[1]) index = 2'd1;
                else                 index = 2'd2;
            end
        endcase
    end

endmodule

// File: rtl/router_out_arb.sv
// router_out_arb: round-robin arbiter draining three packet FIFOs onto one registered byte stream.
// Defining ROUTER_ARB_TIMEOUT_EN adds a stall timeout that soft-resets the granted FIFO.
module router_out_arb
    import router_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [2:0]        fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout0,
    input  logic [DATA_W-1:0] fifo_dout1,
    input  logic [DATA_W-1:0] fifo_dout2,
    input  logic              out_ready,
    output logic [2:0]        read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              vld_out,
    output logic [1:0]        grant,
    output logic              busy,
    output logic [2:0]        soft_reset
);

    state_t            state, state_nxt;
    logic [1:0]        last_grant;
    logic [1:0]        pick_idx;
    logic              pick_any;
    logic [2:0]        request;
    logic              grant_empty;
    logic              rd_issue;
    logic              pkt_end;
    logic              stall_hit;
    logic              rd_d1;
    logic [1:0]        rd_idx;
    logic [REM_W-1:0]  remaining;
    logic [LEN_W-1:0]  hdr_len;
    logic [DATA_W-1:0] rd_data;

    assign request = ~fifo_empty;

    router_rr_pick u_pick (
        .request (request),
        .last    (last_grant),
        .index   (pick_idx),
        .any     (pick_any)
    );

    assign grant_empty = fifo_empty[grant];
    assign busy        = (state != IDLE);
    // Gated by resetn so no byte is popped from a FIFO in a cycle whose packet is being abandoned.
    assign read_enb    = (rd_issue && resetn) ? onehot3(grant) : 3'b000;

    always_comb begin
        hdr_len = fifo_dout2[LEN_MSB:LEN_LSB];
        case (grant)
            2'd0:    hdr_len = fifo_dout0[LEN_MSB:LEN_LSB];
            2'd1:    hdr_len = fifo_dout1[LEN_MSB:LEN_LSB];
            default: hdr_len = fifo_dout2[LEN_MSB:LEN_LSB];
        endcase
    end

    always_comb begin
        rd_data = fifo_dout2;
        case (rd_idx)
            2'd0:    rd_data = fifo_dout0;
            2'd1:    rd_data = fifo_dout1;
            default: rd_data = fifo_dout2;
        endcase
    end

    always_comb begin
        state_nxt = state;
        rd_issue  = 1'b0;
        pkt_end   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) state_nxt = GRANT;
            end
            GRANT: begin
                if (out_ready && !grant_empty) begin
                    rd_issue  = 1'b1;
                    state_nxt = HDR;
                end
            end
            HDR: begin
                state_nxt = BODY;
            end
            BODY: begin
                if (out_ready && !grant_empty && (remaining != '0)) begin
                    rd_issue = 1'b1;
                    if (remaining == REM_W'(1)) begin
                        pkt_end   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (stall_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset lives inside the clocked block; state uses <= so every register sees pre-edge values.
        if (!resetn) begin
            state      <= IDLE;
            grant      <= 2'd0;
            last_grant <= 2'd2;
            remaining  <= '0;
            rd_d1      <= 1'b0;
            rd_idx     <= 2'd0;
            data_out   <= '0;
            vld_out    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_any) grant <= pick_idx;
            if (pkt_end || stall_hit) last_grant <= grant;
            if (state == HDR)
                remaining <= {1'b0, hdr_len} + REM_W'(1);
            else if (rd_issue && state == BODY)
                remaining <= remaining - REM_W'(1);
            // FIFO data arrives one cycle after the strobe and is registered one cycle later.
            rd_d1   <= rd_issue;
            rd_idx  <= grant;
            vld_out <= rd_d1;
            if (rd_d1) data_out <= rd_data;
        end
    end

`ifdef ROUTER_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] stall_cnt;

    assign stall_hit = (state == BODY) && grant_empty && (stall_cnt == STALL_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cnt  <= '0;
            soft_reset <= 3'b000;
        end else begin
            soft_reset <= stall_hit ? onehot3(grant) : 3'b000;
            if (state == BODY && grant_empty && !stall_hit)
                stall_cnt <= stall_cnt + 1'b1;
            else
                stall_cnt <= '0;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign stall_hit      = 1'b0;
    assign soft_reset     = 3'b000;
`endif

endmodule
